// File: rtl/vblank_sched.sv
// Vertical-blanking update scheduler: shares each blanking window between
// requesters with round-robin req/grant/done and a per-grant timeout.
module vblank_sched #(
    parameter int N_REQ    = 4,
    parameter int V_ACTIVE = 600,
    parameter int TIMEOUT  = 2048
) (
    input  logic             pixel_clk,
    input  logic             sim_rst,
    input  logic [11:0]      v_coord,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic             window_open,
    output logic             frame_start,
    output logic [15:0]      frame_cnt,
    output logic             timeout_err,
    output logic             overrun,
    output logic [N_REQ-1:0] missed
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [11:0]   V_FIRST_BLANK = 12'(V_ACTIVE);
    localparam logic [TW-1:0] TIMER_LAST    = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX      = IW'(N_REQ - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARB  = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             vb_q;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [N_REQ-1:0] served_q, served_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [15:0]      frameCnt_q, frameCnt_d;
    logic [N_REQ-1:0] missed_q, missed_d;
    logic             frameStart_q, frameStart_d;
    logic             timeoutErr_q, timeoutErr_d;
    logic             overrun_q, overrun_d;

    logic             blank;
    logic             openEv;
    logic             closeEv;
    logic             busy;
    logic             doneK;
    logic [N_REQ-1:0] eligible;
    logic             pickFound;
    logic [IW-1:0]    pickIdx;
    logic [IW-1:0]    nextPtr;
    logic [N_REQ-1:0] servedWithK;

    assign blank       = (v_coord >= V_FIRST_BLANK);
    assign openEv      = blank && !vb_q;
    assign closeEv     = !blank && vb_q;
    assign busy        = (state_q == S_BUSY);
    assign doneK       = busy && done[idx_q];
    assign eligible    = req & ~served_q;
    assign nextPtr     = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    assign servedWithK = served_q | (N_REQ'(1) << idx_q);

    // First eligible requester at or after the round-robin pointer, wrapping.
    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pickFound && eligible[(int'(ptr_q) + i) % N_REQ]) begin
                pickFound = 1'b1;
                pickIdx   = IW'((int'(ptr_q) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        served_d     = served_q;
        ptr_d        = ptr_q;
        frameCnt_d   = frameCnt_q;
        missed_d     = missed_q;
        frameStart_d = 1'b0;
        timeoutErr_d = 1'b0;
        overrun_d    = 1'b0;

        // A close preempts everything; a completion in the same cycle still counts.
        if (closeEv) begin
            state_d      = S_IDLE;
            grant_d      = '0;
            frameStart_d = 1'b1;
            frameCnt_d   = frameCnt_q + 16'd1;
            overrun_d    = busy && !doneK;
            if (doneK) begin
                served_d = servedWithK;
                ptr_d    = nextPtr;
            end
            missed_d = req & ~served_d;
        end else begin
            case (state_q)
                S_IDLE: begin
                    grant_d = '0;
                    if (openEv) begin
                        served_d = '0;
                        state_d  = S_ARB;
                    end
                end
                S_ARB: begin
                    if (pickFound) begin
                        grant_d = N_REQ'(1) << pickIdx;
                        idx_d   = pickIdx;
                        timer_d = '0;
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    timer_d = timer_q + 1'b1;
                    if (doneK || (timer_q == TIMER_LAST)) begin
                        timeoutErr_d = !doneK;
                        served_d     = servedWithK;
                        ptr_d        = nextPtr;
                        grant_d      = '0;
                        state_d      = S_ARB;
                    end
                end
                default: begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (sim_rst) begin
            state_q      <= S_IDLE;
            vb_q         <= 1'b0;
            grant_q      <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            served_q     <= '0;
            ptr_q        <= '0;
            frameCnt_q   <= '0;
            missed_q     <= '0;
            frameStart_q <= 1'b0;
            timeoutErr_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            vb_q         <= blank;
            grant_q      <= grant_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            served_q     <= served_d;
            ptr_q        <= ptr_d;
            frameCnt_q   <= frameCnt_d;
            missed_q     <= missed_d;
            frameStart_q <= frameStart_d;
            timeoutErr_q <= timeoutErr_d;
            overrun_q    <= overrun_d;
        end
    end

    assign grant       = grant_q;
    assign window_open = vb_q;
    assign frame_start = frameStart_q;
    assign frame_cnt   = frameCnt_q;
    assign timeout_err = timeoutErr_q;
    assign overrun     = overrun_q;
    assign missed      = missed_q;

endmodule

// File: doc/vblank_sched.md
# vblank_sched

Vertical-blanking update scheduler. It shares the per-frame blanking window between up to `N_REQ` game-logic requesters that must update shared frame state, such as sprite positions, score or background registers, outside active video. It watches the `display_ctrl` coordinates and runs a round-robin req/grant/done handshake with a per-grant timeout. It sits beside `display_ctrl` and `game_top` and reports frame events and scheduling faults.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `V_ACTIVE`, 600: first blanking line; lines `>= V_ACTIVE` are blanking.
- `TIMEOUT`, 2048: maximum cycles a grant may be held (>= 2).

Ports:
- `pixel_clk`, in, 1: the single clock.
- `sim_rst`, in, 1: synchronous, active-high reset.
- `v_coord`, in, 12: vertical pixel coordinate from `display_ctrl`.
- `req`, in, `N_REQ`: level request, one bit per requester.
- `done`, in, `N_REQ`: one-cycle completion pulse from the granted requester.
- `grant`, out, `N_REQ`: one-hot or zero; the holder owns shared state.
- `window_open`, out, 1: high while inside the blanking window.
- `frame_start`, out, 1: one-cycle pulse when the window closes, i.e. active video begins.
- `frame_cnt`, out, 16: frame counter; wraps `0xFFFF -> 0`.
- `timeout_err`, out, 1: one-cycle pulse when a grant is revoked by timeout.
- `overrun`, out, 1: one-cycle pulse when the window closes while a grant is held.
- `missed`, out, `N_REQ`: requesters still pending and unserved at the last window close; held until the next close.

## Operation
- `vb_q` is the register of `(v_coord >= V_ACTIVE)`, and `window_open = vb_q`.
- Open event: `(v_coord >= V_ACTIVE) && !vb_q`.
- Close event: `(v_coord < V_ACTIVE) && vb_q`.
- FSM states are `IDLE`, `ARB` and `BUSY`.
- `IDLE`:
  - grant = 0.
  - On an open event, clear the `served` mask and go to `ARB`.
- `ARB`:
  - `eligible = req & ~served`.
  - If `eligible` is nonzero, pick the first set bit at or after `ptr`, wrapping mod `N_REQ`.
  - Register `grant[k]=1`, clear the timer to 0, go to `BUSY`.
  - Otherwise stay in `ARB`; eligibility is re-evaluated every cycle.
- `BUSY` (holding index `k`):
  - The timer increments every cycle.
  - `done[k]`: set `served[k]`, set `ptr = (k+1) mod N_REQ`, clear grant, go to `ARB`.
  - Timer `== TIMEOUT-1` without `done[k]`: same actions as `done[k]`, plus pulse `timeout_err`.
  - `done` bits of non-granted requesters are ignored.
  - Dropping `req[k]` while granted does not revoke the grant; only `done`, timeout or close end it.
- Each requester is granted at most once per window.
- `ptr` persists across frames, so fairness carries over frame boundaries.
- Close event, in any state:
  - Go to `IDLE` and clear grant.
  - Pulse `frame_start`.
  - Increment `frame_cnt`.
  - `missed <= req & ~served`, with the mask including any completion in this same cycle.
  - If in `BUSY` and `done[k]` is not asserted this cycle, pulse `overrun`; `served[k]` stays clear, so `k` appears in `missed` if it is still requesting.
- Simultaneous events:
  - `done[k]` with timeout expiry: done wins, no `timeout_err`.
  - `done[k]` with close: counts as served, no `overrun`.
  - Close and open can never coincide.
- Reset values:
  - `grant=0`, `window_open=0`, `frame_start=0`, `frame_cnt=0`, `timeout_err=0`, `overrun=0`, `missed=0`.
  - Internally `ptr=0`, `served=0`, state `IDLE`.
- Reset mid-window: after release, `vb_q=0`. If `v_coord` is still in blanking, an open event fires on the first cycle after release and the window reopens with a fresh `served` mask.

## Timing
- `window_open` rises 1 cycle after `v_coord` first reaches `V_ACTIVE`, and falls 1 cycle after `v_coord` returns below it.
- Grant latency:
  - Open event at cycle t: `ARB` at t+1, `grant` visible at t+2 if `req` was already high.
  - In `ARB`, `grant` is visible 1 cycle after `req` is seen.
- Release: `done` sampled at cycle t drops `grant` at t+1. The next grant appears at t+2 at the earliest, giving one dead cycle between grants.
- Timeout: a grant first visible at cycle g is revoked with `grant` low at g+`TIMEOUT`; `timeout_err` is high in that same cycle.
- Close at cycle t: `frame_start`, `overrun`, `grant=0`, the new `missed` and the incremented `frame_cnt` are all visible at t+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench parameters: `V_ACTIVE=600`, `TIMEOUT=16`, `N_REQ=4`; `v_coord` is stepped directly.
- Basic grant:
  - Stimulus: `req=4'b0101`, `v_coord` 599 -> 600.
  - Response: `grant=0001` 2 cycles later; after `done[0]`, `grant=0100` 2 cycles later; after `done[2]`, `grant` stays 0; at close, `frame_start` pulses, `frame_cnt` 0 -> 1, `missed=0`.
- Round-robin across frames:
  - Stimulus: `req=4'b1111`; each window allows exactly one grant to complete before close.
  - Response: first grants go to 0, 1, 2, 3 across four frames; `missed` equals `1110`, `1101`, `1011`, `0111`.
- Timeout:
  - Stimulus: grant `0010`, `done` never asserted.
  - Response: `grant` drops exactly 16 cycles after it rose; `timeout_err` pulses once in that cycle; requester 1 is not re-granted this window.
- Simultaneous events:
  - Stimulus: `done[k]` on the timeout cycle.
  - Response: no `timeout_err`.
  - Stimulus: `done[k]` on the close cycle.
  - Response: no `overrun` and `missed[k]=0`.
- Overrun:
  - Stimulus: grant held when `v_coord` goes 627 -> 0.
  - Response: `overrun=1` and `grant=0` next cycle; `missed[k]=1`.
- Reset mid-window:
  - Stimulus: `sim_rst` pulsed while `grant=0100` and `v_coord=610`.
  - Response: all outputs 0 during reset; after release, `window_open=1` after 1 cycle and `grant=0001` for `req=4'b0101`, since `ptr` was reset to 0.
